// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard controller.
//   state_t     - MULT/DIV occupancy FSM states (IDLE, MD_RUN, MD_DONE)
//   md_type_t   - id_md_type encodings (MULT, MULTU, DIV, DIVU)
//   REG_ZERO    - architectural $0, never a hazard source
//   reg_match() - "ID instruction reads register r" compare
//   md_is_div() - true for DIV/DIVU
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_type_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The ID instruction depends on r when r is a real register and one of
  // its used source fields names it.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rs,
                                     input logic       uses_rt);
    reg_match = (r != REG_ZERO) &&
                ((uses_rs && (rs == r)) || (uses_rt && (rt == r)));
  endfunction

  function automatic logic md_is_div(input logic [1:0] md_type);
    md_is_div = (md_type == MD_DIV) || (md_type == MD_DIVU);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_seq.sv
// md_busy_seq: occupancy sequencer for the multi-cycle MULT/DIV unit.
// A down-counter tracks the remaining EX occupancy of the accepted op.
//   clk, rst   - clock (rising edge), async active-high reset
//   md_accept  - MD op leaves ID this cycle (already qualified by !stall)
//   md_is_div  - accepted op is DIV/DIVU (else MULT/MULTU)
//   md_busy    - unit occupied (MD_RUN)
//   md_done    - one-cycle result-ready pulse (MD_DONE)
//   md_stall   - hold the front end while the unit is occupied
//   md_state   - current FSM state, exported for observation
module md_busy_seq
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   md_accept,
  input  logic   md_is_div,
  output logic   md_busy,
  output logic   md_done,
  output logic   md_stall,
  output state_t md_state
);

  // Counter holds "cycles left after this one", so a load of N-1 yields
  // exactly N cycles in MD_RUN.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] load_val;

  assign load_val = md_is_div ? DIV_LOAD : MULT_LOAD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_accept) begin
          state_d = MD_RUN;
          cnt_d   = load_val;
        end
      end
      MD_RUN: begin
        if (cnt_q == '0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DONE: begin
        // A back-to-back op held during MD_RUN is accepted here.
        if (md_accept) begin
          state_d = MD_RUN;
          cnt_d   = load_val;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_busy  = (state_q == MD_RUN);
  assign md_stall = (state_q == MD_RUN);
  assign md_done  = (state_q == MD_DONE);
  assign md_state = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / bubble controller for the 5-stage pipeline.
// Build option: define HAZ_PERF_CNT_EN to get a saturating stall-cycle
// counter on stall_cycles; otherwise stall_cycles is constant zero.
//   clk, rst                 - clock (rising edge), async active-high reset
//   id_rs/id_rt, id_uses_*   - source registers read by the ID instruction
//   id_is_branch             - ID branch compares operands in ID
//   id_branch_taken          - ID branch/jump resolves taken
//   id_md_start, id_md_type  - ID instruction is a MULT/DIV op and its kind
//   ex_mem_read/ex_reg_write/ex_rd - EX stage destination info
//   mem_mem_read/mem_rd      - MEM stage load destination info
//   stall        - hold PC and IF/ID
//   branch_flush - clear IF/ID (never together with stall)
//   id_ex_bubble - insert NOP into ID/EX
//   md_busy, md_done - MULT/DIV occupancy and result-ready pulse
//   stall_cycles - performance counter (see build option)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_branch,
  input  logic        id_branch_taken,
  input  logic        id_md_start,
  input  logic [1:0]  id_md_type,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_rd,
  output logic        stall,
  output logic        branch_flush,
  output logic        id_ex_bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);

  logic   ex_match, mem_match;
  logic   load_use, br_hz, md_stall;
  logic   md_accept;
  state_t md_state;

  assign ex_match  = reg_match(ex_rd,  id_rs, id_rt, id_uses_rs, id_uses_rt);
  assign mem_match = reg_match(mem_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);

  assign load_use = ex_mem_read && ex_match;

  // Branches compare in ID, so any EX producer is too late to forward and
  // a MEM load has not returned data yet.
  assign br_hz = id_is_branch &&
                 ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));

  assign stall        = load_use | br_hz | md_stall;
  assign id_ex_bubble = stall;
  // A stalled branch has no trustworthy decision yet; flush waits for it.
  assign branch_flush = id_branch_taken && !stall;

  // Starts seen during MD_RUN are stalled (md_stall) and re-presented later.
  assign md_accept = id_md_start && !stall && (md_state != MD_RUN);

  md_busy_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_seq (
    .clk       (clk),
    .rst       (rst),
    .md_accept (md_accept),
    .md_is_div (md_is_div(id_md_type)),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .md_stall  (md_stall),
    .md_state  (md_state)
  );

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= 32'd0;
    end else if (stall && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule
